yuv_stream_checker: RTL
=======================

# yuv_stream_checker

Parametrised self-checking monitor for the ISP's packed YUV output stream. It tracks frame and line framing, skips a configurable number of warm-up lines per frame, and compares every valid beat against region-specific expected words: first line, middle lines or last line, with separate head and body words. Beyond a sticky error flag, it counts mismatches, captures the first failing beat, checks line length and frame height, and pulses at frame end. It sits in the top-level testbench on the pipeline output, alongside the stimulus generator.

## Interface
Parameters:
- `DATA_W`, 64: width of `yuv_data_i`.
- `IMG_HEIGHT`, 512: checked lines per frame, after skipping. Must be ≥ 3.
- `BEATS_PER_LINE`, 128: valid beats expected per checked line. Must be ≥ 2.
- `SKIP_LINES`, 3: lines ignored at the start of each frame.
- `ERR_CNT_W`, 16: width of the mismatch counter.
- `EXP_FIRST_HEAD` / `EXP_FIRST_BODY`, `DATA_W` bits: expected words for line 0, beat 0 and beats ≥ 1.
- `EXP_MID_HEAD` / `EXP_MID_BODY`: expected words for lines 1 .. `IMG_HEIGHT`-2.
- `EXP_LAST_HEAD` / `EXP_LAST_BODY`: expected words for line `IMG_HEIGHT`-1.

Ports:
- `clk_i`, in, 1: clock; all logic on the rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `clear_i`, in, 1: synchronous clear of all statistics and sticky flags.
- `frame_valid_i`, in, 1: frame envelope.
- `line_valid_i`, in, 1: line envelope.
- `yuv_valid_i`, in, 1: data beat qualifier.
- `yuv_data_i`, in, `DATA_W`: beat data.
- `error_o`, out, 1: sticky; a data mismatch has been seen.
- `err_count_o`, out, `ERR_CNT_W`: mismatch count, saturating at all-ones.
- `first_err_line_o`, out, `$clog2(IMG_HEIGHT)`: checked-line index of the first mismatch.
- `first_err_beat_o`, out, `$clog2(BEATS_PER_LINE+1)`: beat index of the first mismatch.
- `first_err_data_o`, out, `DATA_W`: received data of the first mismatch.
- `line_len_err_o`, out, 1: sticky; a checked line ended with a beat count ≠ `BEATS_PER_LINE`.
- `frame_len_err_o`, out, 1: sticky; a frame ended with a checked-line count ≠ `IMG_HEIGHT`.
- `frame_done_o`, out, 1: one-cycle pulse at the end of each armed frame.

## Operation
- **Edge detection.**
  - `frame_valid_i` and `line_valid_i` are registered into `fv_q` and `lv_q`.
  - A rise is `x & !x_q`; a fall is `!x & x_q`.
  - `fv_q` and `lv_q` reset to 1, so a frame already in progress when reset releases produces no false start.
- **Arming.**
  - `armed` is cleared by reset.
  - A frame rise sets `armed`, sets `skip_cnt` = 0 and sets `line_idx` = 0.
  - While `armed` = 0, nothing is checked or flagged.
- **Line rise while armed.**
  - If `skip_cnt` < `SKIP_LINES`: increment `skip_cnt`. The line is uncounted and its beats are ignored.
  - Otherwise the line is counted: `beat_cnt` = 0, and the line uses index `line_idx`.
- **Line fall on a counted line.**
  - If `beat_cnt` ≠ `BEATS_PER_LINE`, set `line_len_err_o`.
  - Increment `line_idx`, saturating at `IMG_HEIGHT`.
- **Region of a counted line.**
  - `line_idx` = 0: FIRST.
  - `line_idx` in 1 .. `IMG_HEIGHT`-2: MID.
  - `line_idx` = `IMG_HEIGHT`-1: LAST.
  - `line_idx` ≥ `IMG_HEIGHT`: OVER. Beats are not compared; `frame_len_err_o` is set at frame fall.
- **Beat selection.**
  - Compare only when `yuv_valid_i` & `line_valid_i` & counted line & region ≠ OVER.
  - `beat_cnt` = 0 selects the HEAD word of the region; otherwise the BODY word.
  - `beat_cnt` increments per valid beat, saturating at `BEATS_PER_LINE`+1. Beats past that are still compared against BODY.
- **Check pipeline.**
  - Stage 1 registers the data, the selected expected word, `line_idx`, `beat_cnt` and a check-valid bit.
  - Stage 2 compares the registered data with the registered expected word.
- **On mismatch in stage 2:**
  - set `error_o`;
  - increment `err_count_o`, saturating;
  - if `err_count_o` was 0, capture the `first_err_*` outputs.
- **Frame fall while armed.**
  - If the checked-line count ≠ `IMG_HEIGHT`, set `frame_len_err_o`.
  - Pulse `frame_done_o` and clear `armed`.
- **Simultaneous events.**
  - Frame rise and line rise in the same cycle: the frame start applies first, and the line is the first skip candidate of the new frame.
  - Line fall then line rise on consecutive cycles is legal.
  - A `yuv_valid_i` beat in the same cycle as a counted line rise is beat 0 of that line.
- **`clear_i`.**
  - Zeroes `error_o`, `err_count_o`, `first_err_*`, `line_len_err_o` and `frame_len_err_o`.
  - Discards the stage-2 compare result of that cycle.
  - Framing state (`armed`, counters) is untouched.
- **Reset.** Every output is 0. `armed` = 0, all counters are 0, and the pipeline is invalid. Reset mid-frame abandons that frame; checking resumes at the next frame rise.

## Timing
- A beat presented before rising edge N is registered at N and compared at N+1. `error_o`, `err_count_o` and `first_err_*` are updated after edge N+1.
- `line_len_err_o` is set after the edge that samples the line fall.
- `frame_done_o` and `frame_len_err_o` become high after the edge that samples the frame fall. `frame_done_o` is high for exactly one cycle.
- No back-pressure: the block accepts one beat per cycle indefinitely.

## Test plan
Benches use `IMG_HEIGHT` = 4, `BEATS_PER_LINE` = 4, `SKIP_LINES` = 1.
- **Clean frame.** One skip line plus 4 lines × 4 correct beats. Required: `error_o` = 0, `err_count_o` = 0, both length flags 0, one `frame_done_o` pulse.
- **Single mismatch.** Corrupt line 2, beat 3 with 0xDEAD. Required: `error_o` = 1, `err_count_o` = 1, `first_err_line_o` = 2, `first_err_beat_o` = 3, `first_err_data_o` = 0xDEAD, with the update 2 edges after the beat.
- **Line and frame length.** Drive 3 beats on line 1. Required: `line_len_err_o` = 1. Drive only 3 counted lines. Required: `frame_len_err_o` = 1 at the frame fall.
- **Skip and head/body selection.** Garbage on the skip line and correct data elsewhere. Required: no error. A HEAD word driven at beat 1 is flagged.
- **Reset mid-frame.** Assert reset during line 2 while `frame_valid_i` stays high. Required: all outputs 0 and no checking until the next frame rise; the following clean frame passes.
- **Clear and saturation.** Force more than 2^`ERR_CNT_W` mismatches. Required: `err_count_o` saturates at all-ones. Then `clear_i`: all statistics 0, while the frame in progress continues to be checked.

Source files
------------

// File: rtl/yuv_stream_checker.sv
// Self-checking monitor for the packed YUV output stream: frame/line framing,
// region-based expected words, mismatch statistics and line/frame length checks.
module yuv_stream_checker #(
    parameter int                DATA_W         = 64,
    parameter int                IMG_HEIGHT     = 512,
    parameter int                BEATS_PER_LINE = 128,
    parameter int                SKIP_LINES     = 3,
    parameter int                ERR_CNT_W      = 16,
    parameter logic [DATA_W-1:0] EXP_FIRST_HEAD = '0,
    parameter logic [DATA_W-1:0] EXP_FIRST_BODY = '0,
    parameter logic [DATA_W-1:0] EXP_MID_HEAD   = '0,
    parameter logic [DATA_W-1:0] EXP_MID_BODY   = '0,
    parameter logic [DATA_W-1:0] EXP_LAST_HEAD  = '0,
    parameter logic [DATA_W-1:0] EXP_LAST_BODY  = '0
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  clear_i,
    input  logic                                  frame_valid_i,
    input  logic                                  line_valid_i,
    input  logic                                  yuv_valid_i,
    input  logic [DATA_W-1:0]                     yuv_data_i,
    output logic                                  error_o,
    output logic [ERR_CNT_W-1:0]                  err_count_o,
    output logic [$clog2(IMG_HEIGHT)-1:0]         first_err_line_o,
    output logic [$clog2(BEATS_PER_LINE+1)-1:0]   first_err_beat_o,
    output logic [DATA_W-1:0]                     first_err_data_o,
    output logic                                  line_len_err_o,
    output logic                                  frame_len_err_o,
    output logic                                  frame_done_o
);

    localparam int LINE_OUT_W = $clog2(IMG_HEIGHT);
    localparam int BEAT_OUT_W = $clog2(BEATS_PER_LINE + 1);
    // Internal counters carry one extra value so the saturation points are representable.
    localparam int LINE_W     = $clog2(IMG_HEIGHT + 1);
    localparam int BEAT_W     = $clog2(BEATS_PER_LINE + 2);
    localparam int SKIP_W     = $clog2(SKIP_LINES + 2);

    localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(IMG_HEIGHT);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_HEIGHT - 1);
    localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(BEATS_PER_LINE);
    localparam logic [BEAT_W-1:0] BEAT_SAT  = BEAT_W'(BEATS_PER_LINE + 1);
    localparam logic [SKIP_W-1:0] SKIP_END  = SKIP_W'(SKIP_LINES);

    typedef enum logic [1:0] {
        REGION_FIRST,
        REGION_MID,
        REGION_LAST,
        REGION_OVER
    } region_e;

    logic                  r_fvQ, r_lvQ, r_armed, r_counted, r_over;
    logic [SKIP_W-1:0]     r_skipCnt;
    logic [LINE_W-1:0]     r_lineIdx;
    logic [BEAT_W-1:0]     r_beatCnt;

    logic                  w_frameRise, w_frameFall, w_lineRise, w_lineFall;
    logic                  w_armedEff, w_countedEff, w_skipLine, w_startLine;
    logic                  w_lineEnd, w_countBeat, w_doCheck, w_frameBad;
    logic [SKIP_W-1:0]     w_skipEff;
    logic [LINE_W-1:0]     w_idxEff, w_idxInc, w_linesAtEnd;
    logic [BEAT_W-1:0]     w_beatEff;
    region_e               w_region;
    logic [DATA_W-1:0]     w_expWord;

    logic                  r_s1Valid;
    logic [DATA_W-1:0]     r_s1Data, r_s1Exp;
    logic [LINE_OUT_W-1:0] r_s1Line;
    logic [BEAT_OUT_W-1:0] r_s1Beat;

    logic                  r_error, r_lineLenErr, r_frameLenErr, r_frameDone;
    logic [ERR_CNT_W-1:0]  r_errCount;
    logic [LINE_OUT_W-1:0] r_firstLine;
    logic [BEAT_OUT_W-1:0] r_firstBeat;
    logic [DATA_W-1:0]     r_firstData;

    assign w_frameRise  = frame_valid_i & ~r_fvQ;
    assign w_frameFall  = ~frame_valid_i & r_fvQ;
    assign w_lineRise   = line_valid_i & ~r_lvQ;
    assign w_lineFall   = ~line_valid_i & r_lvQ;
    assign w_lineEnd    = w_lineFall & r_counted & r_armed;
    assign w_idxInc     = (r_lineIdx == LINE_END) ? r_lineIdx : r_lineIdx + LINE_W'(1);
    assign w_linesAtEnd = w_lineEnd ? w_idxInc : r_lineIdx;
    // A line past the last one saturates the index, so r_over remembers the overrun.
    assign w_frameBad   = (w_linesAtEnd != LINE_END) | r_over;

    // A frame start in this cycle takes precedence, so a coincident line rise is judged
    // against the fresh frame state; a counted line rise makes this cycle's beat beat 0.
    always_comb begin
        w_armedEff   = r_armed | w_frameRise;
        w_skipEff    = w_frameRise ? '0 : r_skipCnt;
        w_idxEff     = w_frameRise ? '0 : r_lineIdx;
        w_countedEff = r_counted & r_armed & ~w_frameRise;
        w_beatEff    = r_beatCnt;
        w_skipLine   = 1'b0;
        w_startLine  = 1'b0;
        if (w_lineRise && w_armedEff) begin
            if (w_skipEff < SKIP_END) begin
                w_skipLine = 1'b1;
            end else begin
                w_startLine  = 1'b1;
                w_countedEff = 1'b1;
                w_beatEff    = '0;
            end
        end

        if (w_idxEff == '0)
            w_region = REGION_FIRST;
        else if (w_idxEff < LINE_LAST)
            w_region = REGION_MID;
        else if (w_idxEff == LINE_LAST)
            w_region = REGION_LAST;
        else
            w_region = REGION_OVER;

        case (w_region)
            REGION_FIRST: w_expWord = (w_beatEff == '0) ? EXP_FIRST_HEAD : EXP_FIRST_BODY;
            REGION_MID:   w_expWord = (w_beatEff == '0) ? EXP_MID_HEAD   : EXP_MID_BODY;
            REGION_LAST:  w_expWord = (w_beatEff == '0) ? EXP_LAST_HEAD  : EXP_LAST_BODY;
            default:      w_expWord = '0;
        endcase

        w_countBeat = yuv_valid_i & line_valid_i & w_countedEff;
        w_doCheck   = w_countBeat & (w_region != REGION_OVER);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fvQ     <= 1'b1;
            r_lvQ     <= 1'b1;
            r_armed   <= 1'b0;
            r_counted <= 1'b0;
            r_over    <= 1'b0;
            r_skipCnt <= '0;
            r_lineIdx <= '0;
            r_beatCnt <= '0;
        end else begin
            r_fvQ <= frame_valid_i;
            r_lvQ <= line_valid_i;
            if (w_frameRise) begin
                r_armed   <= 1'b1;
                r_counted <= 1'b0;
                r_over    <= 1'b0;
                r_skipCnt <= '0;
                r_lineIdx <= '0;
            end
            if (w_skipLine)
                r_skipCnt <= w_skipEff + SKIP_W'(1);
            if (w_startLine) begin
                r_counted <= 1'b1;
                if (w_idxEff == LINE_END)
                    r_over <= 1'b1;
                r_beatCnt <= w_countBeat ? BEAT_W'(1) : '0;
            end else if (w_countBeat && (r_beatCnt != BEAT_SAT)) begin
                r_beatCnt <= r_beatCnt + BEAT_W'(1);
            end
            if (w_lineEnd) begin
                r_counted <= 1'b0;
                r_lineIdx <= w_idxInc;
            end
            if (w_frameFall && r_armed) begin
                r_armed   <= 1'b0;
                r_counted <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
            r_s1Exp   <= '0;
            r_s1Line  <= '0;
            r_s1Beat  <= '0;
        end else begin
            r_s1Valid <= w_doCheck;
            r_s1Data  <= yuv_data_i;
            r_s1Exp   <= w_expWord;
            r_s1Line  <= w_idxEff[LINE_OUT_W-1:0];
            r_s1Beat  <= w_beatEff[BEAT_OUT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_error       <= 1'b0;
            r_errCount    <= '0;
            r_firstLine   <= '0;
            r_firstBeat   <= '0;
            r_firstData   <= '0;
            r_lineLenErr  <= 1'b0;
            r_frameLenErr <= 1'b0;
            r_frameDone   <= 1'b0;
        end else begin
            r_frameDone <= w_frameFall & r_armed;
            if (clear_i) begin
                r_error       <= 1'b0;
                r_errCount    <= '0;
                r_firstLine   <= '0;
                r_firstBeat   <= '0;
                r_firstData   <= '0;
                r_lineLenErr  <= 1'b0;
                r_frameLenErr <= 1'b0;
            end else begin
                if (w_lineEnd && (r_beatCnt != BEAT_FULL))
                    r_lineLenErr <= 1'b1;
                if (w_frameFall && r_armed && w_frameBad)
                    r_frameLenErr <= 1'b1;
                if (r_s1Valid && (r_s1Data != r_s1Exp)) begin
                    r_error <= 1'b1;
                    if (r_errCount != '1)
                        r_errCount <= r_errCount + ERR_CNT_W'(1);
                    if (r_errCount == '0) begin
                        r_firstLine <= r_s1Line;
                        r_firstBeat <= r_s1Beat;
                        r_firstData <= r_s1Data;
                    end
                end
            end
        end
    end

    assign error_o          = r_error;
    assign err_count_o      = r_errCount;
    assign first_err_line_o = r_firstLine;
    assign first_err_beat_o = r_firstBeat;
    assign first_err_data_o = r_firstData;
    assign line_len_err_o   = r_lineLenErr;
    assign frame_len_err_o  = r_frameLenErr;
    assign frame_done_o     = r_frameDone;

endmodule
